sap_datapath: RTL
=================

SAP_DATAPATH -- requirements
Module: sap_datapath

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have ports CP, EP, EA, SU, EU, inputs, 1 bit each, all active-high: PC count, PC-to-bus, A-to-bus, subtract select, ALU-to-bus.
REQ-004 SHALL have ports LM_n, CE_n, LI_n, EI_n, LA_n, LB_n, LO_n, inputs, 1 bit each, all active-low: MAR load, RAM-to-bus, IR load, IR-operand-to-bus, A load, B load, OUT load.
REQ-005 SHALL have port prog_we, input, 1 bit: program-port write enable.
REQ-006 SHALL have port prog_addr, input, 4 bits: program-port address.
REQ-007 SHALL have port prog_data, input, 8 bits: program-port write data.
REQ-008 SHALL have port IRData, output, 4 bits: opcode field IR[7:4], returned to the controller.
REQ-009 SHALL have port out_data, output, 8 bits: output register.
REQ-010 SHALL have port bus, output, 8 bits: W-bus monitor.
REQ-011 SHALL have port bus_err, output, 1 bit: combinational flag, high when more than one bus driver is enabled.

Function
REQ-012 SHALL hold internal state PC[3:0], MAR[3:0], IR[7:0], A[7:0], B[7:0], OUT[7:0] and RAM of 16x8.
REQ-013 Bus drivers SHALL be: EP -> {4'h0,PC}; CE_n=0 -> RAM[MAR]; EI_n=0 -> {4'h0,IR[3:0]}; EA -> A; EU -> ALU.
REQ-014 With no driver enabled, bus SHALL be 8'h00.
REQ-015 With multiple drivers enabled, bus_err SHALL be 1 and bus SHALL take the highest-priority driver, in the order EP > CE_n > EI_n > EA > EU.
REQ-016 ALU SHALL be combinational: SU=0 -> A+B; SU=1 -> A-B (two's complement); result truncated to 8 bits, carry/borrow discarded.
REQ-017 At each rising edge, every active load (MAR<=bus[3:0], IR<=bus, A<=bus, B<=bus, OUT<=bus) SHALL capture the pre-edge bus value; latency is one cycle.
REQ-018 CP=1 SHALL set PC<=PC+1 modulo 16 (15 wraps to 0); CP together with EP SHALL drive the old PC value.
REQ-019 Simultaneous LA_n=0 and EA=1 SHALL leave A unchanged; simultaneous LA_n=0, EU=1 SHALL load the ALU result computed from the pre-edge A.
REQ-020 RAM read SHALL be asynchronous from MAR.
REQ-021 prog_we=1 SHALL write RAM[prog_addr]<=prog_data at the edge; a read of the same address in that cycle SHALL return the old data.
REQ-022 IRData SHALL equal IR[7:4] combinationally; out_data SHALL equal OUT.
REQ-023 The block SHALL perform no opcode decoding; sequencing belongs to the controller. Opcode encoding: LDA=0, ADD=1, SUB=2, OUT=3, HLT=4.

Reset
REQ-024 reset=1 at an edge SHALL clear PC, MAR, IR, A, B, OUT to 0 and SHALL override all loads and CP in that cycle.
REQ-025 Reset SHALL NOT clear RAM; prog_we SHALL be honored during reset so a program can be loaded while reset is held.
REQ-026 After reset: IRData=4'h0, out_data=8'h00, bus=8'h00 (all control inputs inactive), bus_err=0.

Structure
REQ-027 Shared package sap_pkg SHALL hold the opcode constants, the data width (8) and the address width (4).
REQ-028 The RAM, including its program port, SHALL be one sub-module, sap_ram16x8; the bus multiplexer, ALU and registers SHALL remain in sap_datapath.

Verification
REQ-029 Program-load and fetch: load RAM[0]=8'h09 under reset, release reset, pulse EP+LM_n=0, then CP, then CE_n+LI_n=0 -> MAR=0, PC=1, IRData=4'h0, IR=8'h09.
REQ-030 Full program driven by the controller sequence: RAM {0:09, 1:1A, 2:2B, 3:30, 4:40, 9:10, A:14, B:18} -> out_data=8'h0C after OUT, PC=5 at HLT.
REQ-031 Wrap: set A=8'hF0, B=8'h20; EU+LA_n=0 gives A=8'h10; with SU=1 from A=8'h05, B=8'h07, the result is A=8'hFE. Sixteen CP pulses from PC=0 -> PC=0.
REQ-032 Contention: EP=1 and EA=1 with PC=3, A=8'h55 -> bus_err=1, bus=8'h03; no drivers -> bus=8'h00, bus_err=0.
REQ-033 Reset mid-operation: assert reset in the same cycle as LA_n=0 with bus=8'h77 -> A=8'h00; RAM contents are intact afterwards.
REQ-034 Program port during read: prog_we to RAM[MAR]=8'h3C while CE_n+LB_n=0 and the old value is 8'h11 -> B=8'h11, and the next read gives 8'h3C.

Source files
------------

// File: rtl/sap_pkg.sv
// Shared widths and opcode encoding for the SAP-1 datapath.
package sap_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned RAM_DEPTH = 16;

  // Opcode field IR[7:4]; decoded by the controller, not by the datapath.
  typedef enum logic [3:0] {
    OP_LDA = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_OUT = 4'h3,
    OP_HLT = 4'h4
  } opcode_e;

endpackage

// File: rtl/sap_datapath_if.sv
// Program-load port bundle: the loader writes the RAM while the datapath runs or sits in reset.
interface sap_datapath_if;
  import sap_pkg::*;

  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;

  modport master (output we, output addr, output wdata);
  modport slave  (input  we, input  addr, input  wdata);

endinterface

// File: rtl/sap_ram16x8.sv
// 16x8 program/data RAM: asynchronous read from MAR, synchronous write from the program port.
module sap_ram16x8
  import sap_pkg::*;
(
  input  logic               clk,
  sap_datapath_if.slave      prog,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [DATA_W-1:0]  rdata
);

  logic [DATA_W-1:0] mem [RAM_DEPTH];

  // Program-port write; not reset so a program survives reset.
  always_ff @(posedge clk) begin
    if (prog.we) mem[prog.addr] <= prog.wdata;
  end

  // Same-cycle read of a written address returns the old word.
  assign rdata = mem[raddr];

endmodule

// File: rtl/sap_datapath.sv
// SAP-1 datapath: W-bus multiplexer, ALU and PC/MAR/IR/A/B/OUT registers around a 16x8 RAM.
module sap_datapath
  import sap_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              CP,
  input  logic              EP,
  input  logic              EA,
  input  logic              SU,
  input  logic              EU,
  input  logic              LM_n,
  input  logic              CE_n,
  input  logic              LI_n,
  input  logic              EI_n,
  input  logic              LA_n,
  input  logic              LB_n,
  input  logic              LO_n,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [3:0]        IRData,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] bus,
  output logic              bus_err
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic [DATA_W-1:0] out_reg;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] alu;
  logic [2:0]        drv_cnt;

  sap_datapath_if prog_port ();

  assign prog_port.we    = prog_we;
  assign prog_port.addr  = prog_addr;
  assign prog_port.wdata = prog_data;

  sap_ram16x8 u_ram (
    .clk   (clk),
    .prog  (prog_port.slave),
    .raddr (mar),
    .rdata (ram_rdata)
  );

  // Add/subtract, carry and borrow dropped by truncation.
  assign alu = SU ? DATA_W'(a_reg - b_reg) : DATA_W'(a_reg + b_reg);

  // Priority bus mux; lower-priority drivers are ignored on contention.
  always_comb begin
    bus = '0;
    if (EP)         bus = DATA_W'(pc);
    else if (!CE_n) bus = ram_rdata;
    else if (!EI_n) bus = DATA_W'(ir[3:0]);
    else if (EA)    bus = a_reg;
    else if (EU)    bus = alu;
  end

  // Contention flag: more than one driver enabled.
  assign drv_cnt = 3'(EP) + 3'(!CE_n) + 3'(!EI_n) + 3'(EA) + 3'(EU);
  assign bus_err = (drv_cnt > 3'd1);

  // Register loads capture the pre-edge bus; reset overrides every load and CP.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= '0;
      mar     <= '0;
      ir      <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      out_reg <= '0;
    end else begin
      if (CP)    pc      <= ADDR_W'(pc + 1'b1);
      if (!LM_n) mar     <= bus[ADDR_W-1:0];
      if (!LI_n) ir      <= bus;
      if (!LA_n) a_reg   <= bus;
      if (!LB_n) b_reg   <= bus;
      if (!LO_n) out_reg <= bus;
    end
  end

  assign IRData   = ir[7:4];
  assign out_data = out_reg;

endmodule
